multi_timeout_timer: RTL and testbench
======================================

# multi_timeout_timer

Parametrised multi-channel timeout generator for the memory-game datapath. It replaces the fixed count-to-100 timer: each channel has a terminal count latched at start, a one-shot or periodic mode, abort, and restart. It counts strobes of a shared enable (e.g. a 1 ms tick) and drives one-cycle `timeout` pulses to the game FSM for LED-sequence pacing, player-response windows and debounce holds.

## Interface
- `CHANNELS`, default 4: number of independent timer channels.
- `WIDTH`, default 16: width of each channel's counter and terminal value.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `enable`  in  1: shared count strobe; a running channel advances only in cycles where it is 1.
- `start`  in  CHANNELS: per-channel start/restart request, sampled each cycle.
- `stop`  in  CHANNELS: per-channel abort request, sampled each cycle.
- `periodic`  in  CHANNELS: mode latched at start; 1 = auto-reload, 0 = one-shot.
- `term_val`  in  CHANNELS*WIDTH: terminal counts; channel i uses bits [i*WIDTH +: WIDTH], latched at start.
- `timeout`  out  CHANNELS: one-cycle registered expiry pulse per channel.
- `busy`  out  CHANNELS: 1 while the channel is in RUN.
- `count`  out  CHANNELS*WIDTH: current counter value per channel, same packing as `term_val`.

## Operation
- Each channel is independent and has two states, IDLE and RUN. Registers: `cnt`, `term_q`, `mode_q`, `timeout`.
- Reset (`rst`=0): all channels go to IDLE; `cnt`, `term_q`, `mode_q`, `timeout`, `busy` and `count` all become 0. Reset overrides every other input.
- Priority per channel, evaluated each cycle: reset > stop > start > count.
- `stop[i]`=1: go to IDLE, `cnt`←0, no timeout pulse. This holds in any state, including the cycle in which expiry would have occurred. `stop` together with `start` gives IDLE.
- `start[i]`=1, no stop: `cnt`←0, `term_q`←`term_val` slice, `mode_q`←`periodic[i]`, go to RUN. This works from IDLE or RUN; from RUN it is a restart, and no timeout is pulsed in that cycle.
- RUN with `enable`=1 and `cnt`≠`term_q`: `cnt`←`cnt`+1.
- RUN with `enable`=1 and `cnt`==`term_q`: `timeout[i]`←1 for the next cycle, and `cnt`←0. A one-shot channel goes to IDLE; a periodic channel stays in RUN.
- RUN with `enable`=0: hold.
- IDLE: counter holds at 0 and ignores `enable`.
- Expiry period is `term_q`+1 enable strobes. `term_q`=0 expires on the first enable strobe after start.
- Arithmetic: `cnt` is unsigned WIDTH-bit. It cannot exceed `term_q`, so it never wraps.
- Changes to `term_val` or `periodic` while in RUN are ignored until the next start.

## Timing
- `timeout` is registered. It is high exactly during the cycle after the clock edge on which the terminal enable strobe was sampled, and is 0 otherwise.
- `busy` and `count` are direct register outputs, with no combinational path from inputs.
- Start to first possible count: the start edge loads the channel; an `enable` in the following cycle gives the first increment.
- Back-to-back periodic expiries: with `enable` held at 1 and `term_q`=N, `timeout` pulses every N+1 cycles; with N=0 it is high on every cycle.
- `start` arriving during the `timeout`-high cycle restarts cleanly; the pulse already issued is not cancelled.

## Structure
- Shared package/header `timer_pkg` holds the state encoding (IDLE=1'b0, RUN=1'b1) and the mode constants MODE_ONESHOT=0 and MODE_PERIODIC=1.
- Sub-module `timeout_channel` (parameter WIDTH) holds one channel's FSM, counter and latches.
- The top level instantiates `timeout_channel` CHANNELS times in a generate loop and only slices and concatenates the buses.

## Test plan
- Reset: hold `rst`=0 with random inputs for 3 cycles. All outputs must be 0; after release, channels stay IDLE until a start.
- One-shot, WIDTH=16, `term_val`[0]=100, `enable` held at 1: `timeout[0]` pulses exactly once, 101 cycles after the start edge; `busy[0]` then drops; no further pulses.
- Periodic, `term_val`[1]=3, `enable` high every other cycle: `timeout[1]` pulses every 8 cycles for at least 5 periods; `count[1]` cycles through 0,1,2,3.
- Stop and restart: `stop[2]` asserted in the terminal cycle gives no pulse and IDLE. A re-`start[2]` at `count`=5 of a term=10 run resets `count` to 0 and gives a full 11-strobe wait.
- Edge cases: `term_val`=0 one-shot pulses after the first strobe; `start`+`stop` in the same cycle gives IDLE. Changing `term_val` mid-run has no effect.
- Independence: all 4 channels run with terms 2, 5, 7, 100 and mixed modes. Each channel's pulse train must match a per-channel reference model cycle-for-cycle.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timeout timer: channel state and mode constants.
package timer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage : timer_pkg

// File: rtl/timeout_channel.sv
// One timeout channel: IDLE/RUN FSM, counter, latched terminal count and mode,
// and a registered one-cycle expiry pulse.
module timeout_channel
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
   input  logic [WIDTH-1:0] term_val,
   output logic             timeout,
   output logic             busy,
   output logic [WIDTH-1:0] count
);

   chan_state_e      state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] term_q, term_d;
   logic             mode_q, mode_d;
   logic             timeout_q, timeout_d;

   // State register; synchronous active-low reset clears everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         term_q    <= '0;
         mode_q    <= MODE_ONESHOT;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         term_q    <= term_d;
         mode_q    <= mode_d;
         timeout_q <= timeout_d;
      end
   end

   // Next state: stop beats start, start beats counting.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      term_d    = term_q;
      mode_d    = mode_q;
      timeout_d = 1'b0;

      if (stop) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (start) begin
         state_d = ST_RUN;
         cnt_d   = '0;
         term_d  = term_val;
         mode_d  = periodic;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (enable) begin
                  if (cnt_q == term_q) begin
                     timeout_d = 1'b1;
                     cnt_d     = '0;
                     if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q + WIDTH'(1);
                  end
               end
            end
            default: begin
               cnt_d = '0;
            end
         endcase
      end
   end

   assign timeout = timeout_q;
   assign busy    = (state_q == ST_RUN);
   assign count   = cnt_q;

endmodule : timeout_channel

// File: rtl/multi_timeout_timer.sv
// Multi-channel timeout generator: CHANNELS independent timeout_channel instances
// sharing one count strobe; the top level only slices and concatenates buses.
module multi_timeout_timer
   import timer_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [CHANNELS-1:0]       start,
   input  logic [CHANNELS-1:0]       stop,
   input  logic [CHANNELS-1:0]       periodic,
   input  logic [CHANNELS*WIDTH-1:0] term_val,
   output logic [CHANNELS-1:0]       timeout,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS*WIDTH-1:0] count
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      timeout_channel #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .enable   (enable),
         .start    (start[i]),
         .stop     (stop[i]),
         .periodic (periodic[i]),
         .term_val (term_val[i*WIDTH +: WIDTH]),
         .timeout  (timeout[i]),
         .busy     (busy[i]),
         .count    (count[i*WIDTH +: WIDTH])
      );
   end

endmodule : multi_timeout_timer

// File: tb/tb_multi_timeout_timer.sv
// Self-checking bench for multi_timeout_timer: reset, a directed vector table on
// channel 0, hand-written corner sequences, and a per-channel reference model.
module tb_multi_timeout_timer;

   localparam int unsigned CH = 4;
   localparam int unsigned W  = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [CH-1:0]   start, stop, periodic;
   logic [CH*W-1:0] term_val;
   logic [CH-1:0]   timeout, busy;
   logic [CH*W-1:0] count;

   int total = 0;
   int bad   = 0;

   multi_timeout_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .start    (start),
      .stop     (stop),
      .periodic (periodic),
      .term_val (term_val),
      .timeout  (timeout),
      .busy     (busy),
      .count    (count)
   );

   always #5 clk = ~clk;

   // Reference model state, one entry per channel.
   logic         m_run  [CH];
   logic [W-1:0] m_cnt  [CH];
   logic [W-1:0] m_term [CH];
   logic         m_per  [CH];
   logic         m_to   [CH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < CH; i++) begin
         if (!rst) begin
            m_run[i] = 1'b0; m_cnt[i] = '0; m_term[i] = '0; m_per[i] = 1'b0; m_to[i] = 1'b0;
         end else begin
            m_to[i] = 1'b0;
            if (stop[i]) begin
               m_run[i] = 1'b0;
               m_cnt[i] = '0;
            end else if (start[i]) begin
               m_run[i]  = 1'b1;
               m_cnt[i]  = '0;
               m_term[i] = term_val[i*W +: W];
               m_per[i]  = periodic[i];
            end else if (m_run[i] && enable) begin
               if (m_cnt[i] == m_term[i]) begin
                  m_to[i]  = 1'b1;
                  m_cnt[i] = '0;
                  if (!m_per[i]) m_run[i] = 1'b0;
               end else begin
                  m_cnt[i] = m_cnt[i] + 16'd1;
               end
            end
         end
      end
   endtask

   // One clock: advance the model with the inputs sampled at the edge, then compare.
   task automatic step();
      logic [CH-1:0]   e_to, e_busy;
      logic [CH*W-1:0] e_cnt;
      @(posedge clk);
      model_update();
      #1;
      for (int i = 0; i < CH; i++) begin
         e_to[i]          = m_to[i];
         e_busy[i]        = m_run[i];
         e_cnt[i*W +: W]  = m_cnt[i];
      end
      check("model_timeout", 64'(timeout), 64'(e_to));
      check("model_busy",    64'(busy),    64'(e_busy));
      check("model_count",   64'(count),   64'(e_cnt));
   endtask

   function automatic logic [W-1:0] cnt_of(input int ch);
      return count[ch*W +: W];
   endfunction

   typedef struct {
      logic         st;
      logic         sp;
      logic         per;
      logic         en;
      logic [W-1:0] tv;
      logic         e_to;
      logic         e_busy;
      logic [W-1:0] e_cnt;
   } vec_t;

   vec_t tbl [16];

   initial begin
      int first, pulses, last, maxc;
      logic seen;

      // Channel 0 directed vectors: {start, stop, periodic, enable, term, exp timeout, busy, count}.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd1};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 16'd1};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd2};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0, 16'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 16'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 16'd0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 16'd0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 16'd0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 16'd0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1, 16'd1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1, 16'd2};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b1, 16'd3};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd9, 1'b1, 1'b0, 16'd0};

      // Reset with random inputs.
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         enable   = 1'($urandom);
         start    = CH'($urandom);
         stop     = CH'($urandom);
         periodic = CH'($urandom);
         term_val = {$urandom, $urandom};
         step();
         check("rst_timeout", 64'(timeout), 64'd0);
         check("rst_busy",    64'(busy),    64'd0);
         check("rst_count",   64'(count),   64'd0);
      end
      rst = 1'b1; enable = 1'b1; start = '0; stop = '0; periodic = '0; term_val = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("idle_after_rst", 64'(busy), 64'd0);
      end

      // Table-driven vectors on channel 0.
      for (int v = 0; v < 16; v++) begin
         start    = {3'b000, tbl[v].st};
         stop     = {3'b000, tbl[v].sp};
         periodic = {3'b000, tbl[v].per};
         enable   = tbl[v].en;
         term_val = {48'd0, tbl[v].tv};
         step();
         check($sformatf("vec%0d_timeout", v), 64'(timeout[0]), 64'(tbl[v].e_to));
         check($sformatf("vec%0d_busy", v),    64'(busy[0]),    64'(tbl[v].e_busy));
         check($sformatf("vec%0d_count", v),   64'(cnt_of(0)),  64'(tbl[v].e_cnt));
      end
      start = '0; stop = '0; periodic = '0; term_val = '0;

      // One-shot term=100 with enable held: single pulse 101 cycles after start.
      enable = 1'b1; start = 4'b0001; term_val[0 +: W] = 16'd100;
      step();
      start = '0; first = -1; pulses = 0;
      for (int k = 1; k <= 130; k++) begin
         step();
         if (timeout[0]) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      check("oneshot100_latency", 64'(first),   64'd101);
      check("oneshot100_pulses",  64'(pulses),  64'd1);
      check("oneshot100_busy",    64'(busy[0]), 64'd0);

      // Periodic term=3 on channel 1 with enable every other cycle: pulse every 8 cycles.
      enable = 1'b0; start = 4'b0010; periodic = 4'b0010; term_val[1*W +: W] = 16'd3;
      step();
      start = '0; periodic = '0; first = -1; last = -1; pulses = 0; maxc = 0;
      for (int k = 1; k <= 48; k++) begin
         enable = 1'(k % 2);
         step();
         if (int'(cnt_of(1)) > maxc) maxc = int'(cnt_of(1));
         if (timeout[1]) begin
            if (first < 0) first = k;
            else check("periodic_gap", 64'(k - last), 64'd8);
            last = k;
            pulses++;
         end
      end
      check("periodic_first",  64'(first),           64'd7);
      check("periodic_pulses", 64'(pulses >= 5),     64'd1);
      check("periodic_maxcnt", 64'(maxc),            64'd3);
      check("periodic_busy",   64'(busy[1]),         64'd1);
      stop = 4'b0010; step(); stop = '0;

      // Stop in the terminal cycle suppresses the pulse.
      enable = 1'b1; start = 4'b0100; term_val[2*W +: W] = 16'd10;
      step();
      start = '0;
      for (int k = 0; k < 10; k++) step();
      check("stop_pre_cnt", 64'(cnt_of(2)), 64'd10);
      stop = 4'b0100;
      step();
      stop = '0;
      check("stop_term_timeout", 64'(timeout[2]), 64'd0);
      check("stop_term_busy",    64'(busy[2]),    64'd0);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         seen = seen | timeout[2];
      end
      check("stop_no_late_pulse", 64'(seen), 64'd0);

      // Restart at count 5 of a term=10 run gives a full 11-strobe wait.
      start = 4'b0100;
      step();
      start = '0;
      for (int k = 0; k < 5; k++) step();
      check("restart_pre_cnt", 64'(cnt_of(2)), 64'd5);
      start = 4'b0100; term_val[2*W +: W] = 16'd10;
      step();
      start = '0; term_val[2*W +: W] = 16'd2;
      check("restart_cnt0", 64'(cnt_of(2)), 64'd0);
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (timeout[2] && first < 0) first = k;
      end
      check("restart_latency", 64'(first), 64'd11);

      // Independence: four channels, mixed modes, random enable and term_val churn.
      start = 4'b1111; periodic = 4'b1101;
      term_val = {16'd100, 16'd7, 16'd5, 16'd2};
      enable = 1'b1;
      step();
      start = '0;
      for (int k = 0; k < 400; k++) begin
         enable = ($urandom_range(3) != 0);
         if (k % 37 == 0) begin
            term_val = {$urandom, $urandom};
            periodic = CH'($urandom);
         end
         if (k == 250) start = 4'b0010;
         else start = '0;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_multi_timeout_timer
